nco_voice_scheduler: RTL and testbench

- Time-multiplexes the single combinational NCO scaler/summer datapath (24-bit phase in, 20-bit signed sample out) across NUM_VOICES independent voices.
- Owns per-voice phase accumulators and frequency control words (FCW), and sequences one voice per clock after each sample tick.
- Mixes the voice samples with saturation and hands the mixed sample to the audio output path over a valid/ready handshake.
- Sits between the CPU-facing synth config registers and the DAC sample FIFO.

---
 rtl/nco_voice_scheduler_pkg.sv | 32 +++
 rtl/nco_voice_regfile.sv | 79 +++++++
 rtl/nco_voice_scheduler.sv | 143 ++++++++++++++
 tb/tb_nco_voice_scheduler.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/nco_voice_scheduler_pkg.sv
// Shared audio definitions: datapath widths, scheduler FSM encoding and a
// saturating narrow-to-sample helper that any mixer can reuse.
package nco_voice_scheduler_pkg;

  localparam int PHASE_W  = 24;
  localparam int SAMPLE_W = 20;
  // Widest mix the helper accepts: SAMPLE_W plus headroom for 16 voices.
  localparam int SAT_IN_W = SAMPLE_W + 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } nco_state_e;

  function automatic logic signed [SAMPLE_W-1:0] saturate_sample(
    input logic signed [SAT_IN_W-1:0] value
  );
    logic signed [SAT_IN_W-1:0] hi;
    logic signed [SAT_IN_W-1:0] lo;
    hi = {{(SAT_IN_W-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
    lo = ~hi;
    if (value > hi) begin
      return hi[SAMPLE_W-1:0];
    end else if (value < lo) begin
      return lo[SAMPLE_W-1:0];
    end else begin
      return value[SAMPLE_W-1:0];
    end
  endfunction

endpackage

// File: rtl/nco_voice_regfile.sv
// Per-voice shadow/active FCW and enable registers plus phase accumulators.
// Shadows take CPU writes at any time; the active set changes only on commit.
module nco_voice_regfile
  import nco_voice_scheduler_pkg::*;
#(
  parameter  int NUM_VOICES = 4,
  localparam int IDX_W      = $clog2(NUM_VOICES)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we_i,
  input  logic [IDX_W-1:0]   cfg_voice_i,
  input  logic [PHASE_W-1:0] cfg_fcw_i,
  input  logic               cfg_en_i,
  input  logic               commit_i,
  input  logic               step_i,
  input  logic [IDX_W-1:0]   step_idx_i,
  output logic               step_en_o,
  input  logic [IDX_W-1:0]   la_idx_i,
  input  logic               la_commit_i,
  output logic [PHASE_W-1:0] la_phase_o
);

  logic [PHASE_W-1:0]    fcw_sh_q  [NUM_VOICES];
  logic [PHASE_W-1:0]    fcw_sh_d  [NUM_VOICES];
  logic [PHASE_W-1:0]    fcw_act_q [NUM_VOICES];
  logic [PHASE_W-1:0]    fcw_act_d [NUM_VOICES];
  logic [PHASE_W-1:0]    phase_q   [NUM_VOICES];
  logic [PHASE_W-1:0]    phase_d   [NUM_VOICES];
  logic [NUM_VOICES-1:0] en_sh_q, en_sh_d;
  logic [NUM_VOICES-1:0] en_act_q, en_act_d;

  always_comb begin
    fcw_sh_d  = fcw_sh_q;
    fcw_act_d = fcw_act_q;
    phase_d   = phase_q;
    en_sh_d   = en_sh_q;
    en_act_d  = en_act_q;

    if (cfg_we_i) begin
      fcw_sh_d[cfg_voice_i] = cfg_fcw_i;
      en_sh_d[cfg_voice_i]  = cfg_en_i;
    end

    if (commit_i) begin
      fcw_act_d = fcw_sh_q;
      en_act_d  = en_sh_q;
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (!en_sh_q[i]) phase_d[i] = '0;
      end
    end else if (step_i && en_act_q[step_idx_i]) begin
      phase_d[step_idx_i] = phase_q[step_idx_i] + fcw_act_q[step_idx_i];
    end
  end

  // NOTE: these arrays are reset on purpose -- a reset must lose all config
  // and phase state, so they cannot be left as uninitialised storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      fcw_sh_q  <= '{default: '0};
      fcw_act_q <= '{default: '0};
      phase_q   <= '{default: '0};
      en_sh_q   <= '0;
      en_act_q  <= '0;
    end else begin
      fcw_sh_q  <= fcw_sh_d;
      fcw_act_q <= fcw_act_d;
      phase_q   <= phase_d;
      en_sh_q   <= en_sh_d;
      en_act_q  <= en_act_d;
    end
  end

  assign step_en_o = en_act_q[step_idx_i];

  // Lookahead read shows the phase as it will be once a pending commit lands.
  assign la_phase_o = (la_commit_i && !en_sh_q[la_idx_i]) ? '0 : phase_q[la_idx_i];

endmodule

// File: rtl/nco_voice_scheduler.sv
// Time-multiplexes one shared NCO datapath over NUM_VOICES voices per sample
// tick, mixes with saturation and offers the result on a valid/ready port.
module nco_voice_scheduler
  import nco_voice_scheduler_pkg::*;
#(
  parameter  int NUM_VOICES = 4,
  localparam int IDX_W      = $clog2(NUM_VOICES)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sample_tick_i,
  input  logic                       cfg_we_i,
  input  logic [IDX_W-1:0]           cfg_voice_i,
  input  logic [PHASE_W-1:0]         cfg_fcw_i,
  input  logic                       cfg_en_i,
  output logic [PHASE_W-1:0]         nco_phase_o,
  input  logic signed [SAMPLE_W-1:0] nco_sample_i,
  output logic signed [SAMPLE_W-1:0] sample_out_o,
  output logic                       sample_valid_o,
  input  logic                       sample_ready_i,
  output logic                       busy_o,
  output logic                       overrun_o
);

  localparam int                ACC_W    = SAMPLE_W + IDX_W;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_VOICES - 1);

  nco_state_e                 state_q, state_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic [PHASE_W-1:0]         phase_q, phase_d;
  logic signed [SAMPLE_W-1:0] sample_q, sample_d;
  logic                       valid_q, valid_d;
  logic                       overrun_q, overrun_d;

  logic                       commit, step, step_en, la_commit;
  logic [IDX_W-1:0]           la_idx;
  logic [PHASE_W-1:0]         la_phase;
  logic signed [ACC_W-1:0]    voice_ext, acc_sum;
  logic signed [SAT_IN_W-1:0] sat_in;

  nco_voice_regfile #(.NUM_VOICES(NUM_VOICES)) u_regfile (
    .clk         (clk),
    .rst         (rst),
    .cfg_we_i    (cfg_we_i),
    .cfg_voice_i (cfg_voice_i),
    .cfg_fcw_i   (cfg_fcw_i),
    .cfg_en_i    (cfg_en_i),
    .commit_i    (commit),
    .step_i      (step),
    .step_idx_i  (idx_q),
    .step_en_o   (step_en),
    .la_idx_i    (la_idx),
    .la_commit_i (la_commit),
    .la_phase_o  (la_phase)
  );

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the case statement can infer a latch.
    state_d   = state_q;
    idx_d     = idx_q;
    acc_d     = acc_q;
    phase_d   = '0;
    sample_d  = sample_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    commit    = 1'b0;
    step      = 1'b0;
    la_idx    = idx_q + IDX_W'(1);
    la_commit = 1'b0;

    if (step_en) voice_ext = ACC_W'(nco_sample_i);
    else         voice_ext = '0;
    acc_sum = acc_q + voice_ext;
    sat_in  = SAT_IN_W'(acc_sum);

    unique case (state_q)
      ST_IDLE: begin
        if (sample_tick_i) begin
          commit    = 1'b1;
          idx_d     = '0;
          acc_d     = '0;
          la_idx    = '0;
          la_commit = 1'b1;
          phase_d   = la_phase;
          state_d   = ST_RUN;
        end
      end
      ST_RUN: begin
        overrun_d = overrun_q | sample_tick_i;
        step      = 1'b1;
        if (idx_q == LAST_IDX) begin
          sample_d = saturate_sample(sat_in);
          valid_d  = 1'b1;
          state_d  = ST_HOLD;
        end else begin
          // nco_phase is registered, so present the next voice one cycle early.
          idx_d   = idx_q + IDX_W'(1);
          acc_d   = acc_sum;
          phase_d = la_phase;
        end
      end
      ST_HOLD: begin
        overrun_d = overrun_q | sample_tick_i;
        if (sample_ready_i) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      acc_q     <= '0;
      phase_q   <= '0;
      sample_q  <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      acc_q     <= acc_d;
      phase_q   <= phase_d;
      sample_q  <= sample_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign nco_phase_o    = phase_q;
  assign sample_out_o   = sample_q;
  assign sample_valid_o = valid_q;
  assign busy_o         = (state_q != ST_IDLE);
  assign overrun_o      = overrun_q;

endmodule

// File: tb/tb_nco_voice_scheduler.sv
// Directed-plus-random bench for nco_voice_scheduler against a frame-level
// reference model of voices, phases and the saturating mix.
module tb_nco_voice_scheduler;

  localparam int NV = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sample_tick = 1'b0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_voice = '0;
  logic [23:0] cfg_fcw = '0;
  logic        cfg_en = 1'b0;
  logic [23:0] nco_phase;
  logic [19:0] nco_sample;
  logic [19:0] sample_out;
  logic        sample_valid;
  logic        sample_ready = 1'b0;
  logic        busy;
  logic        overrun;

  // Model of the shared datapath: phase[23:4] or a forced constant.
  logic        dp_const_mode = 1'b0;
  logic [19:0] dp_const = '0;
  assign nco_sample = dp_const_mode ? dp_const : nco_phase[23:4];

  nco_voice_scheduler #(.NUM_VOICES(NV)) dut (
    .clk            (clk),
    .rst            (rst),
    .sample_tick_i  (sample_tick),
    .cfg_we_i       (cfg_we),
    .cfg_voice_i    (cfg_voice),
    .cfg_fcw_i      (cfg_fcw),
    .cfg_en_i       (cfg_en),
    .nco_phase_o    (nco_phase),
    .nco_sample_i   (nco_sample),
    .sample_out_o   (sample_out),
    .sample_valid_o (sample_valid),
    .sample_ready_i (sample_ready),
    .busy_o         (busy),
    .overrun_o      (overrun)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [23:0] m_fcw_sh [NV];
  logic [23:0] m_fcw    [NV];
  logic [23:0] m_phase  [NV];
  bit          m_en_sh  [NV];
  bit          m_en     [NV];
  bit          m_overrun;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int v = 0; v < NV; v++) begin
      m_fcw_sh[v] = '0; m_fcw[v] = '0; m_phase[v] = '0;
      m_en_sh[v] = 1'b0; m_en[v] = 1'b0;
    end
    m_overrun = 1'b0;
  endtask

  task automatic cfg_write(input int v, input logic [23:0] fcw, input bit en);
    @(negedge clk);
    cfg_we = 1'b1; cfg_voice = 2'(v); cfg_fcw = fcw; cfg_en = en;
    m_fcw_sh[v] = fcw; m_en_sh[v] = en;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  // One full frame: tick, NV RUN slots, HOLD for 'hold' cycles (optional tick
  // at cycle tick_at), then handshake.  mid_cfg writes voice1 during RUN.
  task automatic do_frame(input bit mid_cfg, input int hold, input int tick_at);
    logic [23:0] exp_ph [NV];
    logic [23:0] pv;
    logic [19:0] s20;
    logic [19:0] exp_s;
    int acc;
    int s;
    for (int v = 0; v < NV; v++) begin
      m_fcw[v] = m_fcw_sh[v];
      m_en[v]  = m_en_sh[v];
      if (!m_en[v]) m_phase[v] = '0;
    end
    acc = 0;
    for (int v = 0; v < NV; v++) begin
      exp_ph[v] = m_phase[v];
      pv  = m_phase[v];
      s20 = dp_const_mode ? dp_const : pv[23:4];
      s   = $signed(s20);
      if (m_en[v]) begin
        acc = acc + s;
        m_phase[v] = m_phase[v] + m_fcw[v];
      end
    end
    if (acc > 524287)  acc = 524287;
    if (acc < -524288) acc = -524288;
    exp_s = acc[19:0];

    @(negedge clk);
    sample_tick = 1'b1;
    for (int k = 0; k < NV; k++) begin
      @(negedge clk);
      sample_tick = 1'b0;
      cfg_we = 1'b0;
      check($sformatf("run%0d_phase", k), 32'(nco_phase), 32'(exp_ph[k]));
      check($sformatf("run%0d_valid", k), 32'(sample_valid), 32'd0);
      check($sformatf("run%0d_busy", k), 32'(busy), 32'd1);
      if (mid_cfg && k == 1) begin
        cfg_we = 1'b1; cfg_voice = 2'd1; cfg_fcw = 24'h000100; cfg_en = 1'b1;
        m_fcw_sh[1] = 24'h000100; m_en_sh[1] = 1'b1;
      end
    end
    @(negedge clk);
    cfg_we = 1'b0;
    check("latency_valid", 32'(sample_valid), 32'd1);
    check("sample", 32'(sample_out), 32'(exp_s));
    for (int h = 0; h < hold; h++) begin
      if (h == tick_at) begin
        sample_tick = 1'b1;
        m_overrun = 1'b1;
      end
      @(negedge clk);
      sample_tick = 1'b0;
      check("hold_valid", 32'(sample_valid), 32'd1);
      check("hold_sample", 32'(sample_out), 32'(exp_s));
      check("hold_phase", 32'(nco_phase), 32'd0);
    end
    sample_ready = 1'b1;
    @(negedge clk);
    sample_ready = 1'b0;
    check("post_valid", 32'(sample_valid), 32'd0);
    check("post_busy", 32'(busy), 32'd0);
    check("post_sample", 32'(sample_out), 32'(exp_s));
    check("post_overrun", 32'(overrun), 32'(m_overrun));
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_valid", 32'(sample_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_phase", 32'(nco_phase), 32'd0);
    check("rst_sample", 32'(sample_out), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    repeat (20) @(negedge clk);
    check("idle_valid", 32'(sample_valid), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_phase", 32'(nco_phase), 32'd0);
    check("idle_overrun", 32'(overrun), 32'd0);

    // Single voice with phase[23:4] datapath.
    cfg_write(0, 24'h010000, 1'b1);
    repeat (3) do_frame(1'b0, 0, -1);

    // Saturation with constant datapath output.
    dp_const_mode = 1'b1;
    for (int v = 0; v < NV; v++) cfg_write(v, 24'h000010, 1'b1);
    dp_const = 20'h7FFFF; do_frame(1'b0, 1, -1);
    check("sat_pos", 32'(sample_out), 32'h7FFFF);
    dp_const = 20'h80000; do_frame(1'b0, 0, -1);
    check("sat_neg", 32'(sample_out), 32'h80000);
    cfg_write(2, 24'h0, 1'b0);
    cfg_write(3, 24'h0, 1'b0);
    dp_const = 20'h40000; do_frame(1'b0, 0, -1);
    check("sat_two", 32'(sample_out), 32'h7FFFF);

    // Phase wrap: clear everything, then voice0 steps by -1.
    dp_const_mode = 1'b0;
    for (int v = 0; v < NV; v++) cfg_write(v, 24'h0, 1'b0);
    do_frame(1'b0, 0, -1);
    cfg_write(0, 24'hFFFFFF, 1'b1);
    repeat (3) do_frame(1'b0, 0, -1);

    // Backpressure with a dropped tick in HOLD.
    do_frame(1'b0, 10, 4);
    repeat (3) @(negedge clk);
    check("bp_idle_valid", 32'(sample_valid), 32'd0);
    check("bp_idle_busy", 32'(busy), 32'd0);

    // Config during RUN applies from the next frame.
    do_frame(1'b1, 0, -1);
    repeat (2) do_frame(1'b0, 1, -1);

    // Randomized config, datapath mode and backpressure.
    for (int it = 0; it < 10; it++) begin
      if ($urandom_range(0, 1) == 1)
        cfg_write(int'($urandom_range(0, NV - 1)), 24'($urandom), 1'($urandom));
      dp_const_mode = 1'($urandom);
      dp_const = 20'($urandom);
      do_frame(1'b0, int'($urandom_range(0, 3)), -1);
    end

    // Reset in RUN cycle 2: no sample, all state lost.
    dp_const_mode = 1'b0;
    cfg_write(2, 24'h123456, 1'b1);
    @(negedge clk);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int c = 0; c < NV + 3; c++) begin
      check("rst_run_valid", 32'(sample_valid), 32'd0);
      check("rst_run_busy", 32'(busy), 32'd0);
      @(negedge clk);
    end
    check("rst_run_overrun", 32'(overrun), 32'd0);
    do_frame(1'b0, 0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
